// File: rtl/sg_fetch_ctl.sv
// Scatter-gather descriptor chain sequencer: fetches 4-dword descriptors over
// a Wishbone master port, hands them to the data mover and follows the chain.
module sg_fetch_ctl #(
    parameter int unsigned RTY_MAX = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        enable,
    input  logic        ndar_dirty,
    input  logic [28:0] ndar,
    input  logic        append,
    input  logic        wb_int_clear,
    output logic        ndar_dirty_clear,
    output logic        append_clear,
    output logic        wb_int_o,
    output logic        busy,
    output logic [31:0] dar,
    output logic [28:0] next_desc,
    output logic [7:0]  csr,
    output logic [7:0]  ctrl_state,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_cab_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic [31:0] desc_src,
    output logic [31:0] desc_dst,
    output logic [15:0] desc_len,
    output logic [15:0] desc_ctl,
    input  logic        mover_done,
    input  logic        mover_err
);

    typedef enum logic [7:0] {
        StIdle  = 8'h01,
        StFetch = 8'h02,
        StIssue = 8'h04,
        StWait  = 8'h08,
        StAchk  = 8'h10,
        StDone  = 8'h20,
        StError = 8'h80
    } state_e;

    state_e      state_q, state_d;
    logic [28:0] cur_q, cur_d;
    logic [1:0]  beat_q, beat_d;
    logic        eoc_q, eoc_d;
    logic [28:0] nxt_q, nxt_d;
    logic [31:0] w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
    logic [15:0] rty_cnt_q, rty_cnt_d, tmo_cnt_q, tmo_cnt_d;
    logic        gap_q, gap_d;
    logic        abort_q, abort_d;
    logic [7:0]  csr_q, csr_d;
    logic        int_q, int_d;
    logic [31:0] dar_q, dar_d;
    logic [28:0] next_desc_q, next_desc_d;
    logic        int_set;
    logic        aborting;

    // Once enable drops mid-chain the chain winds down even if enable returns.
    assign aborting = abort_q | ~enable;

    assign ctrl_state = state_q;
    assign csr        = csr_q;
    assign wb_int_o   = int_q;
    assign dar        = dar_q;
    assign next_desc  = next_desc_q;
    assign busy       = (state_q == StFetch) || (state_q == StIssue) || (state_q == StWait) ||
                        (state_q == StAchk) || (state_q == StDone);
    assign wbm_cyc_o  = (state_q == StFetch) || (state_q == StAchk);
    // stb is withheld for one cycle after a retry before the beat is repeated.
    assign wbm_stb_o  = wbm_cyc_o & ~gap_q;
    assign wbm_cab_o  = (state_q == StFetch);
    assign wbm_we_o   = 1'b0;
    assign wbm_sel_o  = 4'hf;
    assign wbm_adr_o  = wbm_cyc_o ? ({cur_q, 3'b000} + {28'd0, beat_q, 2'b00}) : 32'd0;
    assign desc_valid = (state_q == StIssue);
    assign desc_src   = w1_q;
    assign desc_dst   = w2_q;
    assign desc_len   = w3_q[15:0];
    assign desc_ctl   = w3_q[31:16];

    // Next-state, bus sequencing and status update.
    always_comb begin
        state_d          = state_q;
        cur_d            = cur_q;
        beat_d           = beat_q;
        eoc_d            = eoc_q;
        nxt_d            = nxt_q;
        w1_d             = w1_q;
        w2_d             = w2_q;
        w3_d             = w3_q;
        rty_cnt_d        = rty_cnt_q;
        tmo_cnt_d        = tmo_cnt_q;
        gap_d            = gap_q;
        abort_d          = abort_q;
        csr_d            = csr_q;
        dar_d            = dar_q;
        next_desc_d      = next_desc_q;
        int_set          = 1'b0;
        ndar_dirty_clear = 1'b0;
        append_clear     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable && ndar_dirty) begin
                    cur_d            = ndar;
                    ndar_dirty_clear = 1'b1;
                    csr_d            = 8'h00;
                    abort_d          = 1'b0;
                    beat_d           = 2'd0;
                    rty_cnt_d        = 16'd0;
                    tmo_cnt_d        = 16'd0;
                    gap_d            = 1'b0;
                    state_d          = StFetch;
                end
            end
            StFetch, StAchk: begin
                abort_d = aborting;
                if (gap_q) begin
                    gap_d = 1'b0;
                    if (aborting) begin
                        csr_d[5] = 1'b1;
                        state_d  = StIdle;
                    end
                end else if (wbm_err_i) begin
                    csr_d[1] = 1'b1;
                    int_set  = 1'b1;
                    state_d  = StError;
                end else if (wbm_ack_i) begin
                    rty_cnt_d = 16'd0;
                    tmo_cnt_d = 16'd0;
                    if (state_q == StAchk) begin
                        eoc_d = wbm_dat_i[0];
                        nxt_d = wbm_dat_i[31:3];
                        if (aborting) begin
                            csr_d[5] = 1'b1;
                            state_d  = StIdle;
                        end else if (!wbm_dat_i[0]) begin
                            cur_d   = wbm_dat_i[31:3];
                            beat_d  = 2'd0;
                            state_d = StFetch;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        unique case (beat_q)
                            2'd0: begin
                                eoc_d = wbm_dat_i[0];
                                nxt_d = wbm_dat_i[31:3];
                            end
                            2'd1: w1_d = wbm_dat_i;
                            2'd2: w2_d = wbm_dat_i;
                            default: w3_d = wbm_dat_i;
                        endcase
                        if (aborting) begin
                            csr_d[5] = 1'b1;
                            state_d  = StIdle;
                        end else if (beat_q == 2'd3) begin
                            beat_d      = 2'd0;
                            dar_d       = {cur_q, 3'b000};
                            next_desc_d = nxt_q;
                            state_d     = StIssue;
                        end else begin
                            beat_d = beat_q + 2'd1;
                        end
                    end
                end else if (wbm_rty_i) begin
                    tmo_cnt_d = 16'd0;
                    if (aborting) begin
                        csr_d[5] = 1'b1;
                        state_d  = StIdle;
                    end else if (rty_cnt_q == 16'(RTY_MAX)) begin
                        csr_d[2] = 1'b1;
                        int_set  = 1'b1;
                        state_d  = StError;
                    end else begin
                        rty_cnt_d = rty_cnt_q + 16'd1;
                        gap_d     = 1'b1;
                    end
                end else if (tmo_cnt_q == 16'(TIMEOUT - 1)) begin
                    csr_d[3] = 1'b1;
                    int_set  = 1'b1;
                    state_d  = StError;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            StIssue: begin
                if (desc_ready) begin
                    abort_d = aborting;
                    state_d = StWait;
                end else if (!enable) begin
                    csr_d[5] = 1'b1;
                    state_d  = StIdle;
                end
            end
            StWait: begin
                abort_d = aborting;
                if (mover_done) begin
                    if (mover_err) begin
                        csr_d[4] = 1'b1;
                        int_set  = 1'b1;
                        state_d  = StError;
                    end else if (aborting) begin
                        csr_d[5] = 1'b1;
                        state_d  = StIdle;
                    end else if (!eoc_q) begin
                        cur_d   = nxt_q;
                        beat_d  = 2'd0;
                        state_d = StFetch;
                    end else if (append) begin
                        append_clear = 1'b1;
                        beat_d       = 2'd0;
                        state_d      = StAchk;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                csr_d[0] = 1'b1;
                int_set  = 1'b1;
                state_d  = StIdle;
            end
            StError: begin
                if (!enable) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Interrupt: a set in the same cycle as a clear wins.
    always_comb begin
        int_d = int_set | (int_q & ~wb_int_clear);
    end

    // State and datapath registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            beat_q      <= '0;
            eoc_q       <= 1'b0;
            nxt_q       <= '0;
            w1_q        <= '0;
            w2_q        <= '0;
            w3_q        <= '0;
            rty_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            gap_q       <= 1'b0;
            abort_q     <= 1'b0;
            csr_q       <= '0;
            int_q       <= 1'b0;
            dar_q       <= '0;
            next_desc_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            beat_q      <= beat_d;
            eoc_q       <= eoc_d;
            nxt_q       <= nxt_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            w3_q        <= w3_d;
            rty_cnt_q   <= rty_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            gap_q       <= gap_d;
            abort_q     <= abort_d;
            csr_q       <= csr_d;
            int_q       <= int_d;
            dar_q       <= dar_d;
            next_desc_q <= next_desc_d;
        end
    end

endmodule

// File: tb/tb_sg_fetch_ctl.sv
// Self-checking bench for sg_fetch_ctl: a Wishbone memory slave and a data
// mover model drive the DUT; expected chains are walked from the memory image.
module tb_sg_fetch_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, ndar_dirty, append, wb_int_clear;
    logic [28:0] ndar;
    logic        ndar_dirty_clear, append_clear, wb_int_o, busy;
    logic [31:0] dar;
    logic [28:0] next_desc;
    logic [7:0]  csr, ctrl_state;
    logic        wbm_cyc_o, wbm_stb_o, wbm_cab_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
    logic        desc_valid, desc_ready;
    logic [31:0] desc_src, desc_dst;
    logic [15:0] desc_len, desc_ctl;
    logic        mover_done, mover_err;

    always #5 clk = ~clk;

    sg_fetch_ctl #(.RTY_MAX(8), .TIMEOUT(255)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .enable(enable), .ndar_dirty(ndar_dirty),
        .ndar(ndar), .append(append), .wb_int_clear(wb_int_clear),
        .ndar_dirty_clear(ndar_dirty_clear), .append_clear(append_clear), .wb_int_o(wb_int_o),
        .busy(busy), .dar(dar), .next_desc(next_desc), .csr(csr), .ctrl_state(ctrl_state),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cab_o(wbm_cab_o),
        .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .wbm_rty_i(wbm_rty_i), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len), .desc_ctl(desc_ctl),
        .mover_done(mover_done), .mover_err(mover_err)
    );

    int checks = 0;
    int errors = 0;

    // Memory image and observation logs.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] read_q[$], exp_reads[$];
    logic [95:0] issued_q[$], exp_desc[$];
    logic [31:0] exp_dar;
    logic [28:0] exp_next;

    // Stimulus configuration (written by tests only).
    bit          zero_wait, silent;
    int          ready_mode, done_min, rty_n;
    logic [31:0] rty_adr;

    // Monitor state (written by the slave/mover process only).
    int rty_seen, done_cnt, ndc_cnt, ac_cnt, cyc_cycles, valid_cycles;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic void put_desc(input logic [28:0] p, input logic [28:0] nxt,
                                     input logic eoc);
        logic [31:0] a;
        a = {p, 3'b000};
        mem[a]          = {nxt, 2'b00, eoc};
        mem[a + 32'd4]  = $urandom;
        mem[a + 32'd8]  = $urandom;
        mem[a + 32'd12] = $urandom;
    endfunction

    // Reference: walk the chain in memory, listing every beat and descriptor.
    function automatic void model_chain(input logic [28:0] head);
        logic [28:0] cur;
        logic [31:0] base, w0;
        cur = head;
        for (int n = 0; n < 16; n++) begin
            base = {cur, 3'b000};
            for (int b = 0; b < 4; b++) exp_reads.push_back(base + 32'(4 * b));
            w0 = mem_rd(base);
            exp_desc.push_back({mem_rd(base + 32'd4), mem_rd(base + 32'd8),
                                mem_rd(base + 32'd12)});
            exp_dar  = base;
            exp_next = w0[31:3];
            if (w0[0]) break;
            cur = w0[31:3];
        end
    endfunction

    function automatic bit q32_eq(input logic [31:0] a[$], input logic [31:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit q96_eq(input logic [95:0] a[$], input logic [95:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Wishbone slave, data mover and event logging; inputs change on negedge,
    // everything is sampled 1 time unit later, well away from posedge.
    always @(negedge clk) begin
        wbm_ack_i  = 1'b0;
        wbm_err_i  = 1'b0;
        wbm_rty_i  = 1'b0;
        wbm_dat_i  = 32'h0;
        mover_done = 1'b0;
        mover_err  = 1'b0;
        desc_ready = 1'b0;
        if (!rst_n) begin
            read_q.delete();
            issued_q.delete();
            rty_seen = 0; done_cnt = 0; ndc_cnt = 0; ac_cnt = 0;
            cyc_cycles = 0; valid_cycles = 0;
        end else begin
            if (wbm_cyc_o && wbm_stb_o && !silent) begin
                if (rty_seen < rty_n && wbm_adr_o == rty_adr) begin
                    wbm_rty_i = 1'b1;
                end else if (zero_wait || $urandom_range(0, 3) != 0) begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = mem_rd(wbm_adr_o);
                end
            end
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) mover_done = 1'b1;
            end
            if (desc_valid) begin
                case (ready_mode)
                    0:       desc_ready = 1'b1;
                    1:       desc_ready = ($urandom_range(0, 1) == 1);
                    default: desc_ready = 1'b0;
                endcase
            end
            #1;
            if (wbm_ack_i) read_q.push_back(wbm_adr_o);
            if (wbm_rty_i) rty_seen++;
            if (wbm_cyc_o) cyc_cycles++;
            if (desc_valid) valid_cycles++;
            if (desc_valid && desc_ready) begin
                issued_q.push_back({desc_src, desc_dst, desc_ctl, desc_len});
                done_cnt = $urandom_range(done_min, done_min + 3);
            end
            if (ndar_dirty_clear) ndc_cnt++;
            if (append_clear) ac_cnt++;
        end
    end

    task automatic reset_dut();
        enable = 1'b0; ndar_dirty = 1'b0; append = 1'b0; wb_int_clear = 1'b0; ndar = '0;
        zero_wait = 1'b1; silent = 1'b0; ready_mode = 0; done_min = 1; rty_n = 0;
        rty_adr = 32'h0;
        mem.delete();
        exp_reads.delete();
        exp_desc.delete();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_chain(input logic [28:0] head);
        ndar = head; ndar_dirty = 1'b1; enable = 1'b1;
        @(negedge clk);
        ndar_dirty = 1'b0;
    endtask

    task automatic wait_state(input logic [7:0] st, input int max, input string name);
        int n = 0;
        while (ctrl_state !== st && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ctrl_state !== st) begin
            $display("FAIL %s: state %h, required %h within %0d cycles", name, ctrl_state, st, max);
            errors++;
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks += 8;
        if (ctrl_state !== 8'h01) begin $display("FAIL reset_state: %h want 01", ctrl_state); errors++; end
        if (csr !== 8'h00) begin $display("FAIL reset_csr: %h want 00", csr); errors++; end
        if (wb_int_o !== 1'b0) begin $display("FAIL reset_int: %b want 0", wb_int_o); errors++; end
        if (busy !== 1'b0) begin $display("FAIL reset_busy: %b want 0", busy); errors++; end
        if (wbm_cyc_o !== 1'b0) begin $display("FAIL reset_cyc: %b want 0", wbm_cyc_o); errors++; end
        if (desc_valid !== 1'b0) begin $display("FAIL reset_valid: %b want 0", desc_valid); errors++; end
        if (dar !== 32'h0) begin $display("FAIL reset_dar: %h want 0", dar); errors++; end
        if (wbm_adr_o !== 32'h0) begin $display("FAIL reset_adr: %h want 0", wbm_adr_o); errors++; end
    endtask

    // A -> B with B at pointer 0 (legal), zero-wait slave.
    task automatic test_two_desc();
        logic [28:0] a;
        reset_dut();
        a = {28'($urandom_range(1, 32'h0fff_ffff)), 1'b0};
        put_desc(a, 29'd0, 1'b0);
        put_desc(29'd0, 29'($urandom), 1'b1);
        model_chain(a);
        start_chain(a);
        wait_state(8'h01, 200, "two_desc_done");
        @(negedge clk);
        checks += 9;
        if (read_q.size() != 8 || !q32_eq(read_q, exp_reads)) begin
            $display("FAIL two_desc_reads: %0d reads, required 8 matching", read_q.size()); errors++;
        end
        if (!q96_eq(issued_q, exp_desc)) begin
            $display("FAIL two_desc_issue: %0d issued, required %0d", issued_q.size(), exp_desc.size());
            errors++;
        end
        if (csr !== 8'h01) begin $display("FAIL two_desc_csr: %h want 01", csr); errors++; end
        if (wb_int_o !== 1'b1) begin $display("FAIL two_desc_int: %b want 1", wb_int_o); errors++; end
        if (ndc_cnt != 1) begin $display("FAIL two_desc_ndc: %0d pulses want 1", ndc_cnt); errors++; end
        if (dar !== exp_dar) begin $display("FAIL two_desc_dar: %h want %h", dar, exp_dar); errors++; end
        if (next_desc !== exp_next) begin
            $display("FAIL two_desc_next: %h want %h", next_desc, exp_next); errors++;
        end
        if (wbm_we_o !== 1'b0 || wbm_sel_o !== 4'hf) begin
            $display("FAIL two_desc_we_sel: we=%b sel=%h want 0/f", wbm_we_o, wbm_sel_o); errors++;
        end
        if (busy !== 1'b0) begin $display("FAIL two_desc_busy: %b want 0", busy); errors++; end
    endtask

    task automatic test_random_chains();
        logic [28:0] base;
        int n;
        for (int k = 0; k < 3; k++) begin
            reset_dut();
            zero_wait = 1'b0;
            ready_mode = 1;
            n = $urandom_range(1, 4);
            base = {28'($urandom), 1'b0};
            for (int i = 0; i < n; i++)
                put_desc(base + 29'(2 * i), base + 29'(2 * (i + 1)), (i == n - 1));
            model_chain(base);
            start_chain(base);
            wait_state(8'h01, 600, "rand_done");
            @(negedge clk);
            checks += 4;
            if (!q32_eq(read_q, exp_reads)) begin
                $display("FAIL rand_reads: %0d reads, required %0d", read_q.size(), exp_reads.size());
                errors++;
            end
            if (!q96_eq(issued_q, exp_desc)) begin
                $display("FAIL rand_issue: %0d issued, required %0d", issued_q.size(), exp_desc.size());
                errors++;
            end
            if (csr !== 8'h01) begin $display("FAIL rand_csr: %h want 01", csr); errors++; end
            if (dar !== exp_dar) begin $display("FAIL rand_dar: %h want %h", dar, exp_dar); errors++; end
        end
    endtask

    task automatic test_retry();
        logic [28:0] a, b;
        // Three retries on beat 2: beat is repeated at the same address.
        reset_dut();
        a = {28'($urandom), 1'b0};
        b = a + 29'd8;
        put_desc(a, b, 1'b0);
        put_desc(b, 29'd0, 1'b1);
        model_chain(a);
        rty_adr = {a, 3'b000} + 32'd8;
        rty_n = 3;
        start_chain(a);
        wait_state(8'h01, 200, "rty3_done");
        @(negedge clk);
        checks += 3;
        if (!q32_eq(read_q, exp_reads)) begin
            $display("FAIL rty3_reads: %0d reads, required %0d", read_q.size(), exp_reads.size());
            errors++;
        end
        if (rty_seen != 3) begin $display("FAIL rty3_count: %0d want 3", rty_seen); errors++; end
        if (csr !== 8'h01) begin $display("FAIL rty3_csr: %h want 01", csr); errors++; end
        // Nine retries exceed the limit of eight.
        reset_dut();
        put_desc(a, b, 1'b0);
        rty_adr = {a, 3'b000} + 32'd8;
        rty_n = 9;
        start_chain(a);
        wait_state(8'h80, 200, "rty9_error");
        checks += 4;
        if (csr !== 8'h04) begin $display("FAIL rty9_csr: %h want 04", csr); errors++; end
        if (rty_seen != 9) begin $display("FAIL rty9_count: %0d want 9", rty_seen); errors++; end
        if (wb_int_o !== 1'b1) begin $display("FAIL rty9_int: %b want 1", wb_int_o); errors++; end
        if (issued_q.size() != 0) begin
            $display("FAIL rty9_issue: %0d issued want 0", issued_q.size()); errors++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ctrl_state !== 8'h80) begin $display("FAIL rty9_hold: %h want 80", ctrl_state); errors++; end
        enable = 1'b0;
        wait_state(8'h01, 5, "rty9_idle");
    endtask

    task automatic test_timeout();
        int v;
        reset_dut();
        silent = 1'b1;
        put_desc(29'h40, 29'd0, 1'b1);
        start_chain(29'h40);
        wait_state(8'h80, 400, "tmo_error");
        checks += 4;
        if (cyc_cycles != 255) begin $display("FAIL tmo_cycles: %0d want 255", cyc_cycles); errors++; end
        if (csr !== 8'h08) begin $display("FAIL tmo_csr: %h want 08", csr); errors++; end
        if (wbm_cyc_o !== 1'b0) begin $display("FAIL tmo_cyc: %b want 0", wbm_cyc_o); errors++; end
        if (wb_int_o !== 1'b1) begin $display("FAIL tmo_int: %b want 1", wb_int_o); errors++; end
        enable = 1'b0;
        wait_state(8'h01, 5, "tmo_idle");
        v = valid_cycles;
        repeat (5) @(negedge clk);
        checks++;
        if (valid_cycles != 0 || v != 0) begin
            $display("FAIL tmo_valid: %0d valid cycles want 0", valid_cycles); errors++;
        end
    endtask

    // Tail has eoc; software appends C (or not) while the tail is in the mover.
    task automatic test_append(input bit reread_eoc);
        logic [28:0] a, c;
        int n;
        reset_dut();
        done_min = 4;
        a = {28'($urandom), 1'b0};
        c = a + 29'd32;
        put_desc(a, 29'($urandom), 1'b1);
        model_chain(a);
        start_chain(a);
        n = 0;
        while (issued_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
        exp_reads.push_back({a, 3'b000});
        if (!reread_eoc) begin
            mem[{a, 3'b000}] = {c, 2'b00, 1'b0};
            put_desc(c, 29'($urandom), 1'b1);
            model_chain(c);
        end
        append = 1'b1;
        n = 0;
        while (ac_cnt == 0 && n < 100) begin @(negedge clk); n++; end
        append = 1'b0;
        wait_state(8'h01, 200, "append_done");
        @(negedge clk);
        checks += 5;
        if (ac_cnt != 1) begin $display("FAIL append_clear: %0d pulses want 1", ac_cnt); errors++; end
        if (!q32_eq(read_q, exp_reads)) begin
            $display("FAIL append_reads: %0d reads, required %0d", read_q.size(), exp_reads.size());
            errors++;
        end
        if (!q96_eq(issued_q, exp_desc)) begin
            $display("FAIL append_issue: %0d issued, required %0d", issued_q.size(), exp_desc.size());
            errors++;
        end
        if (csr !== 8'h01) begin $display("FAIL append_csr: %h want 01", csr); errors++; end
        if (wb_int_o !== 1'b1) begin $display("FAIL append_int: %b want 1", wb_int_o); errors++; end
    endtask

    task automatic test_abort_issue();
        int n, v;
        reset_dut();
        ready_mode = 2;
        put_desc(29'h100, 29'h200, 1'b0);
        put_desc(29'h200, 29'd0, 1'b1);
        start_chain(29'h100);
        n = 0;
        while (!desc_valid && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (desc_valid !== 1'b1) begin $display("FAIL abort_valid_seen: %b want 1", desc_valid); errors++; end
        enable = 1'b0;
        @(negedge clk);
        v = valid_cycles;
        checks += 4;
        if (desc_valid !== 1'b0) begin $display("FAIL abort_valid: %b want 0", desc_valid); errors++; end
        if (csr !== 8'h20) begin $display("FAIL abort_csr: %h want 20", csr); errors++; end
        if (wb_int_o !== 1'b0) begin $display("FAIL abort_int: %b want 0", wb_int_o); errors++; end
        if (ctrl_state !== 8'h01) begin $display("FAIL abort_state: %h want 01", ctrl_state); errors++; end
        repeat (5) @(negedge clk);
        checks++;
        if (valid_cycles != v) begin
            $display("FAIL abort_no_reissue: %0d valid cycles want %0d", valid_cycles, v); errors++;
        end
    endtask

    task automatic test_int_clear();
        int n;
        reset_dut();
        put_desc(29'h300, 29'd0, 1'b1);
        start_chain(29'h300);
        n = 0;
        while (ctrl_state !== 8'h20 && n < 100) begin @(negedge clk); n++; end
        checks += 2;
        if (ctrl_state !== 8'h20) begin $display("FAIL int_done_seen: %h want 20", ctrl_state); errors++; end
        if (wb_int_o !== 1'b0) begin $display("FAIL int_before_done: %b want 0", wb_int_o); errors++; end
        wb_int_clear = 1'b1;
        @(negedge clk);
        wb_int_clear = 1'b0;
        checks += 2;
        if (wb_int_o !== 1'b1) begin $display("FAIL int_set_wins: %b want 1", wb_int_o); errors++; end
        if (ctrl_state !== 8'h01) begin $display("FAIL int_idle: %h want 01", ctrl_state); errors++; end
        wb_int_clear = 1'b1;
        @(negedge clk);
        wb_int_clear = 1'b0;
        checks++;
        if (wb_int_o !== 1'b0) begin $display("FAIL int_cleared: %b want 0", wb_int_o); errors++; end
    endtask

    initial begin
        test_reset();
        test_two_desc();
        test_random_chains();
        test_retry();
        test_timeout();
        test_append(1'b0);
        test_append(1'b1);
        test_abort_issue();
        test_int_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
